// File: rtl/fmc_stream_ctrl_if.sv
// fmc_stream_ctrl_if: FMC pad-side bus between the STM32 host and the stream controller.
//   fmc_addr  host address (only [3:0] decoded by the controller)
//   fmc_din   write data from the pad
//   fmc_dout  read data to the pad, fmc_doe its output enable
//   fmc_ne    chip select, fmc_noe read strobe, fmc_nwe write strobe (all active low, asynchronous)
//   fmc_nwait host wait, active low
interface fmc_stream_ctrl_if;
  logic [15:0] fmc_addr;
  logic [31:0] fmc_din;
  logic [31:0] fmc_dout;
  logic        fmc_doe;
  logic        fmc_ne;
  logic        fmc_noe;
  logic        fmc_nwe;
  logic        fmc_nwait;
  modport master (
    output fmc_addr, fmc_din, fmc_ne, fmc_noe, fmc_nwe,
    input  fmc_dout, fmc_doe, fmc_nwait
  );
  modport slave (
    input  fmc_addr, fmc_din, fmc_ne, fmc_noe, fmc_nwe,
    output fmc_dout, fmc_doe, fmc_nwait
  );
endinterface

// File: rtl/fmc_stream_ctrl.sv
// fmc_stream_ctrl: FMC-to-FIFO transaction controller with register file, underrun counter and level IRQ.
//   clk, reset    system clock; asynchronous active-high reset
//   fmc           FMC pad bus (slave side): strobes are synchronised into clk
//   fifo_rd_en    one-cycle pop strobe; fifo_rdata valid the following cycle
//   fifo_empty    FIFO empty flag; fifo_level FIFO occupancy
//   ctrl          control register (bit0 = IRQ enable); thresh IRQ threshold
//   underrun_cnt  stream reads made while the FIFO was empty (saturating)
//   irq           registered level interrupt: ctrl[0] && fifo_level >= thresh
module fmc_stream_ctrl #(
  parameter int          LVL_W  = 10,
  parameter logic [31:0] POISON = 32'hDEAD_BEEF
) (
  input  logic                clk,
  input  logic                reset,
  fmc_stream_ctrl_if.slave    fmc,
  output logic                fifo_rd_en,
  input  logic [31:0]         fifo_rdata,
  input  logic                fifo_empty,
  input  logic [LVL_W:0]      fifo_level,
  output logic [31:0]         ctrl,
  output logic [LVL_W:0]      thresh,
  output logic [15:0]         underrun_cnt,
  output logic                irq
);
  typedef enum logic [1:0] {IDLE, POP, WAITD, DRIVE} state_t;
  state_t         state_q, state_d;
  // [0],[1] synchroniser stages, [2] history flop for edge detection
  logic [2:0]     ne_q, noe_q, nwe_q;
  logic           rs_q, rd_start, wr_commit, und_inc;
  logic [3:0]     addr_q, wa_q;
  logic [31:0]    wd_q, dout_q, dout_d, ctrl_q, rd_mux;
  logic [LVL_W:0] thresh_q;
  logic [15:0]    und_q;
  logic           irq_q;
  logic           unused_addr;

  assign unused_addr = ^fmc.fmc_addr[15:4];
  assign rd_start = noe_q[2] & ~noe_q[1] & ~ne_q[1];
  // commits are only honoured while idle so a write can never race a read
  assign wr_commit = nwe_q[1] & ~nwe_q[2] & ~ne_q[1] & (state_q == IDLE) & ~rs_q;
  assign rd_mux = addr_q == 4'd0 ? ctrl_q :
                  addr_q == 4'd1 ? 32'(thresh_q) :
                  addr_q == 4'd2 ? {fifo_empty, irq_q, {(29-LVL_W){1'b0}}, fifo_level} :
                  addr_q == 4'd3 ? {16'h0000, und_q} : POISON;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ne_q     <= '1;
      noe_q    <= '1;
      nwe_q    <= '1;
      rs_q     <= 1'b0;
      addr_q   <= '0;
      wa_q     <= '0;
      wd_q     <= '0;
      state_q  <= IDLE;
      dout_q   <= '0;
      ctrl_q   <= '0;
      thresh_q <= '0;
      und_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      ne_q    <= {ne_q[1:0], fmc.fmc_ne};
      noe_q   <= {noe_q[1:0], fmc.fmc_noe};
      nwe_q   <= {nwe_q[1:0], fmc.fmc_nwe};
      rs_q    <= rd_start;
      if (rd_start) addr_q <= fmc.fmc_addr[3:0];
      // keep refreshing the write capture while the strobe is low; commit uses the last one
      if (!nwe_q[1]) begin
        wa_q <= fmc.fmc_addr[3:0];
        wd_q <= fmc.fmc_din;
      end
      state_q <= state_d;
      dout_q  <= dout_d;
      if (wr_commit && wa_q == 4'd0) ctrl_q <= wd_q;
      if (wr_commit && wa_q == 4'd1) thresh_q <= wd_q[LVL_W:0];
      und_q <= (wr_commit && wa_q == 4'd3) ? '0 :
               (und_inc && und_q != 16'hFFFF) ? und_q + 16'd1 : und_q;
      irq_q <= ctrl_q[0] && fifo_level >= thresh_q;
    end

  always_comb begin
    state_d       = state_q;
    dout_d        = dout_q;
    und_inc       = 1'b0;
    fifo_rd_en    = 1'b0;
    fmc.fmc_nwait = 1'b1;
    fmc.fmc_doe   = 1'b0;
    unique case (state_q)
      IDLE: if (rs_q) begin
        fmc.fmc_nwait = 1'b0;
        if (addr_q != 4'd4) begin
          state_d = DRIVE;
          dout_d  = rd_mux;
        end else if (fifo_empty) begin
          state_d = DRIVE;
          dout_d  = '0;
          und_inc = 1'b1;
        end else state_d = POP;
      end
      POP: begin
        fifo_rd_en    = 1'b1;
        fmc.fmc_nwait = 1'b0;
        state_d       = WAITD;
      end
      WAITD: begin
        fmc.fmc_nwait = 1'b0;
        dout_d        = fifo_rdata;
        state_d       = DRIVE;
      end
      DRIVE: begin
        fmc.fmc_doe = 1'b1;
        state_d     = (noe_q[1] | ne_q[1]) ? IDLE : DRIVE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fmc.fmc_dout = dout_q;
  assign ctrl         = ctrl_q;
  assign thresh       = thresh_q;
  assign underrun_cnt = und_q;
  assign irq          = irq_q;
endmodule

// File: tb/tb_fmc_stream_ctrl.sv
// tb_fmc_stream_ctrl: directed plus randomized host traffic against a queue-based register/FIFO model.
module tb_fmc_stream_ctrl;
  localparam int          LVL_W  = 10;
  localparam logic [31:0] POISON = 32'hDEAD_BEEF;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  fmc_stream_ctrl_if bus();
  logic           fifo_rd_en, fifo_empty, irq;
  logic [31:0]    fifo_rdata = '0;
  logic [31:0]    ctrl;
  logic [LVL_W:0] fifo_level, thresh;
  logic [15:0]    underrun_cnt;
  fmc_stream_ctrl #(.LVL_W(LVL_W), .POISON(POISON)) dut (
    .clk(clk), .reset(reset), .fmc(bus),
    .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
    .fifo_level(fifo_level), .ctrl(ctrl), .thresh(thresh),
    .underrun_cnt(underrun_cnt), .irq(irq)
  );

  // FIFO stimulus: words pushed by the host process, popped on fifo_rd_en
  logic [31:0]    mem [256];
  int             n_push = 0, n_pop = 0, rd_cnt = 0;
  logic           ovr_en = 1'b0;
  logic [LVL_W:0] ovr = '0;
  assign fifo_empty = (n_push == n_pop);
  assign fifo_level = ovr_en ? ovr : (LVL_W+1)'(n_push - n_pop);
  always @(posedge clk)
    if (fifo_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (n_push != n_pop) begin
        fifo_rdata <= mem[n_pop % 256];
        n_pop      <= n_pop + 1;
      end
    end

  // reference model
  logic [31:0]    m_ctrl = '0;
  logic [LVL_W:0] m_thresh = '0;
  logic [15:0]    m_und = '0;
  logic [31:0]    exp_q [$];
  int errs = 0, checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[n_push % 256] = w;
    exp_q.push_back(w);
    n_push++;
  endtask

  task automatic host_write(input logic [15:0] a, input logic [31:0] d);
    logic [31:0] old_ctrl;
    old_ctrl = m_ctrl;
    @(negedge clk);
    bus.fmc_addr = a;
    bus.fmc_din  = d;
    bus.fmc_ne   = 1'b0;
    bus.fmc_nwe  = 1'b0;
    repeat (4) @(negedge clk);
    bus.fmc_nwe = 1'b1;
    case (a[3:0])
      4'd0: m_ctrl = d;
      4'd1: m_thresh = d[LVL_W:0];
      4'd3: m_und = '0;
      default: ;
    endcase
    repeat (2) @(negedge clk);
    check("wr_lat_pre", ctrl, old_ctrl);
    @(negedge clk);
    check("wr_ctrl", ctrl, m_ctrl);
    check("wr_thresh", 32'(thresh), 32'(m_thresh));
    check("wr_und", 32'(underrun_cnt), 32'(m_und));
    repeat (2) @(negedge clk);
    bus.fmc_ne = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic host_read(input logic [15:0] a, output logic [31:0] d,
                           output int t_nw, output int t_oe, output int n_nw);
    @(negedge clk);
    bus.fmc_addr = a;
    bus.fmc_ne   = 1'b0;
    repeat (5) @(negedge clk);
    bus.fmc_noe = 1'b0;
    t_nw = -1;
    t_oe = -1;
    n_nw = 0;
    d    = '0;
    for (int k = 1; k <= 20 && t_oe < 0; k++) begin
      @(negedge clk);
      if (!bus.fmc_nwait) begin
        n_nw++;
        if (t_nw < 0) t_nw = k;
      end
      if (bus.fmc_doe) begin
        t_oe = k;
        d    = bus.fmc_dout;
      end
    end
    repeat (3) @(negedge clk);
    bus.fmc_noe = 1'b1;
    bus.fmc_ne  = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_read(input logic [15:0] a, input string tag);
    logic [31:0]    exp, got;
    logic [LVL_W:0] lvl;
    logic           pop, m_irq;
    int             t_nw, t_oe, n_nw, rc0;
    pop   = 1'b0;
    lvl   = ovr_en ? ovr : (LVL_W+1)'(exp_q.size());
    m_irq = m_ctrl[0] && lvl >= m_thresh;
    case (a[3:0])
      4'd0: exp = m_ctrl;
      4'd1: exp = 32'(m_thresh);
      4'd2: exp = 32'(lvl) | {exp_q.size() == 0, m_irq, 30'd0};
      4'd3: exp = 32'(m_und);
      4'd4: if (exp_q.size() == 0) begin
        exp = '0;
        if (m_und != 16'hFFFF) m_und++;
      end else begin
        exp = exp_q.pop_front();
        pop = 1'b1;
      end
      default: exp = POISON;
    endcase
    rc0 = rd_cnt;
    host_read(a, got, t_nw, t_oe, n_nw);
    check({tag, "_data"}, got, exp);
    check({tag, "_nw_at"}, t_nw, 3);
    check({tag, "_oe_at"}, t_oe, pop ? 6 : 4);
    check({tag, "_nw_len"}, n_nw, pop ? 3 : 1);
    check({tag, "_pops"}, rd_cnt - rc0, pop ? 1 : 0);
    check({tag, "_und"}, 32'(underrun_cnt), 32'(m_und));
  endtask

  initial begin
    int r, rc0, t;
    reset        = 1'b1;
    bus.fmc_ne   = 1'b1;
    bus.fmc_noe  = 1'b1;
    bus.fmc_nwe  = 1'b1;
    bus.fmc_addr = '0;
    bus.fmc_din  = '0;
    repeat (3) @(negedge clk);
    check("rst_doe", bus.fmc_doe, 0);
    check("rst_nwait", bus.fmc_nwait, 1);
    check("rst_dout", bus.fmc_dout, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_ctrl", ctrl, 0);
    check("rst_thresh", 32'(thresh), 0);
    check("rst_und", 32'(underrun_cnt), 0);
    check("rst_irq", irq, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    host_write(16'h0000, 32'h1234_5678);
    check("ctrl_val", ctrl, 32'h1234_5678);
    do_read(16'h0000, "ctrl_rd");

    push(32'hA5A5_0001);
    push(32'hA5A5_0002);
    do_read(16'h0004, "stream1");
    do_read(16'h0004, "stream2");

    for (int i = 0; i < 3; i++) do_read(16'h0004, "underrun");
    check("underrun_cnt3", 32'(underrun_cnt), 3);
    host_write(16'h0003, 32'h0000_0000);
    check("underrun_clr", 32'(underrun_cnt), 0);

    host_write(16'h0000, 32'h1);
    host_write(16'h0001, 32'h8);
    ovr_en = 1'b1;
    ovr    = 11'd7;
    repeat (2) @(negedge clk);
    check("irq_lvl7", irq, 0);
    ovr = 11'd8;
    #1 check("irq_lag", irq, 0);
    @(negedge clk);
    check("irq_lvl8", irq, 1);
    ovr = 11'd7;
    @(negedge clk);
    check("irq_back7", irq, 0);
    host_write(16'h0000, 32'h0);
    ovr = 11'd8;
    repeat (2) @(negedge clk);
    check("irq_disabled", irq, 0);
    host_write(16'h0000, 32'h1);
    host_write(16'h0001, 32'h0);
    ovr = 11'd0;
    repeat (2) @(negedge clk);
    check("irq_thresh0", irq, 1);

    host_write(16'h0000, 32'h0);
    push(32'h0BAD_F00D);
    ovr = 11'd5;
    repeat (2) @(negedge clk);
    do_read(16'h0002, "status");
    ovr_en = 1'b0;
    do_read(16'h0009, "unmapped");
    rc0 = rd_cnt;
    host_write(16'h0004, 32'hFFFF_FFFF);
    check("wr_stream_nopop", rd_cnt - rc0, 0);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3) push($urandom);
      else if (r < 5) host_write(16'($urandom), $urandom);
      else if (r < 8) do_read({12'($urandom), 4'd4}, "rnd_stream");
      else do_read(16'($urandom), "rnd_reg");
    end

    while (exp_q.size() != 0) do_read(16'h0004, "drain");
    do_read(16'h0004, "pre_rst_ur");
    host_write(16'h0000, 32'hCAFE_0001);
    @(negedge clk);
    bus.fmc_addr = 16'h0000;
    bus.fmc_ne   = 1'b0;
    repeat (5) @(negedge clk);
    bus.fmc_noe = 1'b0;
    t = 0;
    while (!bus.fmc_doe && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("rst_drive_reached", bus.fmc_doe, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_doe", bus.fmc_doe, 0);
    check("midrst_nwait", bus.fmc_nwait, 1);
    check("midrst_ctrl", ctrl, 0);
    check("midrst_und", 32'(underrun_cnt), 0);
    check("midrst_rd_en", fifo_rd_en, 0);
    @(negedge clk);
    bus.fmc_noe = 1'b1;
    bus.fmc_ne  = 1'b1;
    repeat (3) @(negedge clk);
    reset    = 1'b0;
    m_ctrl   = '0;
    m_thresh = '0;
    m_und    = '0;
    repeat (2) @(negedge clk);
    do_read(16'h0000, "post_rst");
    do_read(16'h0001, "post_rst_th");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
